// File: rtl/alu_stream_pkg.sv
// Shared types and helpers for the ALU stream path.
// Command word layout, FSM states and the golden ALU result function.
package alu_stream_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_XOR = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tg_state_e;

  localparam int CMD_W   = 10;
  localparam int RES_W   = 10;
  localparam int OP1_LSB = 0;
  localparam int OP1_W   = 4;
  localparam int OP2_LSB = 4;
  localparam int OP2_W   = 4;
  localparam int OPC_LSB = 8;
  localparam int OPC_W   = 2;

  function automatic logic [RES_W-1:0] alu_expected(
    input logic [CMD_W-1:0] cmd
  );
    logic [RES_W-1:0] a;
    logic [RES_W-1:0] b;
    alu_op_e          op;
    a  = {6'd0, cmd[OP1_LSB +: OP1_W]};
    b  = {6'd0, cmd[OP2_LSB +: OP2_W]};
    op = alu_op_e'(cmd[OPC_LSB +: OPC_W]);
    alu_expected = '0;
    unique case (op)
      OP_ADD: alu_expected = a + b;
      OP_SUB: alu_expected = a - b;
      OP_MUL: alu_expected = a * b;
      OP_XOR: alu_expected = a ^ b;
      default: alu_expected = '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exp_fifo.sv
// In-order queue of expected results with registered full/empty flags.
// Simultaneous push and pop leave occupancy unchanged.
module alu_exp_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;
  assign dout_o  = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
    full_d  = (cnt_d == DEPTH_C);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/alu_traffic_gen.sv
// LFSR-driven ALU command initiator and in-order result checker.
// Handshake outputs depend only on registered state.
module alu_traffic_gen
  import alu_stream_pkg::*;
#(
  parameter int          NUM_CMDS        = 64,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter int          TIMEOUT         = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [CMD_W-1:0] wdata,
  output logic             wvalid,
  input  logic             wready,
  input  logic [RES_W-1:0] rdata,
  input  logic             rvalid,
  output logic             rready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [7:0]       sent_count,
  output logic [7:0]       recv_count,
  output logic [7:0]       err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    NUM_C = 8'(NUM_CMDS);
  localparam logic [TW-1:0] TO_C  = TW'(TIMEOUT);

  tg_state_e        state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       sent_q, sent_d;
  logic [7:0]       recv_q, recv_d;
  logic [7:0]       err_q, err_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             to_q, to_d;
  logic             active, push, pop, clr;
  logic             q_full, q_empty, mism;
  logic [RES_W-1:0] exp_new, exp_head;

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign wvalid = (state_q == ST_RUN) && (sent_q < NUM_C) && !q_full;
  assign rready = active && !q_empty;
  assign push   = wvalid && wready;
  assign pop    = rready && rvalid;

  // Gated so the command bus reads zero whenever nothing is offered.
  assign wdata   = wvalid ? lfsr_q[CMD_W-1:0] : '0;
  assign exp_new = alu_expected(lfsr_q[CMD_W-1:0]);
  assign mism    = (exp_head != rdata);

  assign busy       = active;
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == 8'd0) && (recv_q == NUM_C) && !to_q;
  assign timeout    = to_q;
  assign sent_count = sent_q;
  assign recv_count = recv_q;
  assign err_count  = err_q;

  alu_exp_fifo #(
    .W     (RES_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (clr),
    .push_i  (push),
    .din_i   (exp_new),
    .pop_i   (pop),
    .dout_o  (exp_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    to_d    = to_q;
    clr     = 1'b0;
    if (push) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                lfsr_q[15:1]};
      sent_d = sent_q + 8'd1;
    end
    if (pop) begin
      recv_d = recv_q + 8'd1;
      if (mism && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          lfsr_d  = LFSR_SEED;
          sent_d  = '0;
          recv_d  = '0;
          err_d   = '0;
          tcnt_d  = '0;
          to_d    = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (pop)           tcnt_d = '0;
        else if (!q_empty) tcnt_d = tcnt_q + TW'(1);
        // Abort wins over normal progress.
        if (tcnt_d == TO_C) begin
          to_d    = 1'b1;
          state_d = ST_DONE;
        end else if ((state_q == ST_RUN) && (sent_q == NUM_C)) begin
          state_d = ST_DRAIN;
        end else if ((state_q == ST_DRAIN) && q_empty) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      sent_q  <= '0;
      recv_q  <= '0;
      err_q   <= '0;
      tcnt_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_alu_traffic_gen.sv
// Bench for alu_traffic_gen: transaction-level model plus directed runs.
// Covers idle, stalls, timeout, mismatch, stress and mid-run reset.
module tb_alu_traffic_gen;

  localparam int          NUM  = 64;
  localparam int          MAXO = 8;
  localparam int          TMO  = 1024;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       wready = 1'b0;
  logic       rvalid = 1'b0;
  logic [9:0] rdata = '0;
  logic [9:0] wdata;
  logic       wvalid, rready, busy, done, pass, timeout;
  logic [7:0] sent_count, recv_count, err_count;

  alu_traffic_gen #(
    .NUM_CMDS        (NUM),
    .MAX_OUTSTANDING (MAXO),
    .LFSR_SEED       (SEED),
    .TIMEOUT         (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .wdata      (wdata),
    .wvalid     (wvalid),
    .wready     (wready),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .sent_count (sent_count),
    .recv_count (recv_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: run phase, counters, expected-result queue, own LFSR.
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;
  mst_t        m_st = M_IDLE;
  int          m_sent = 0, m_recv = 0, m_err = 0, m_tcnt = 0;
  bit          m_to = 1'b0;
  logic [15:0] m_lfsr = SEED;
  int          m_q[$];
  int          log_cur[$];
  int          log1[$];

  function automatic int alu_ref(input int cmd);
    int a, b, op;
    a  = cmd & 15;
    b  = (cmd >> 4) & 15;
    op = (cmd >> 8) & 3;
    case (op)
      0: return a + b;
      1: return (a - b + 1024) % 1024;
      2: return a * b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {^(l & 16'h002D), l[15:1]};
  endfunction

  function automatic bit m_wvalid();
    return (m_st == M_RUN) && (m_sent < NUM) && (m_q.size() < MAXO);
  endfunction

  function automatic bit m_rready();
    return ((m_st == M_RUN) || (m_st == M_DRAIN)) && (m_q.size() > 0);
  endfunction

  function automatic bit m_pass();
    return (m_st == M_DONE) && (m_err == 0) && (m_recv == NUM) && !m_to;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit psh, pp;
    int qn, sp, h;
    if (!reset) begin
      m_st = M_IDLE;
      m_sent = 0; m_recv = 0; m_err = 0; m_tcnt = 0; m_to = 1'b0;
      m_q.delete();
      m_lfsr = SEED;
    end else begin
      psh = m_wvalid() && wready;
      pp  = m_rready() && rvalid;
      qn  = m_q.size();
      sp  = m_sent;
      if (m_st == M_IDLE || m_st == M_DONE) begin
        if (start) begin
          m_st = M_RUN;
          m_sent = 0; m_recv = 0; m_err = 0; m_tcnt = 0; m_to = 1'b0;
          m_q.delete();
          log_cur.delete();
          m_lfsr = SEED;
        end
      end else begin
        if (pp) begin
          h = m_q.pop_front();
          m_recv++;
          if (h != int'(rdata) && m_err < 255) m_err++;
          m_tcnt = 0;
        end else if (qn > 0) begin
          m_tcnt++;
        end
        if (psh) begin
          m_q.push_back(alu_ref(int'(m_lfsr[9:0])));
          log_cur.push_back(int'(wdata));
          m_sent++;
          m_lfsr = lfsr_next(m_lfsr);
        end
        if (m_tcnt == TMO) begin
          m_to = 1'b1;
          m_st = M_DONE;
        end else if (m_st == M_RUN && sp == NUM) begin
          m_st = M_DRAIN;
        end else if (m_st == M_DRAIN && qn == 0) begin
          m_st = M_DONE;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && chk_en) begin
      chk("wvalid", wvalid, m_wvalid());
      chk("wdata", wdata, m_wvalid() ? int'(m_lfsr[9:0]) : 0);
      chk("rready", rready, m_rready());
      chk("busy", busy, (m_st == M_RUN) || (m_st == M_DRAIN));
      chk("done", done, m_st == M_DONE);
      chk("pass", pass, m_pass());
      chk("timeout", timeout, m_to);
      chk("sent_count", sent_count, m_sent);
      chk("recv_count", recv_count, m_recv);
      chk("err_count", err_count, m_err);
    end
  end

  // Responder: 0 low, 1 high, 2 random; golden data from the model queue.
  int wr_mode = 0;
  int rv_mode = 0;
  bit corrupt = 1'b0;

  initial forever begin
    @(negedge clk);
    #1;
    wready = (wr_mode == 2) ? 1'($urandom_range(0, 1)) : (wr_mode == 1);
    rvalid = (rv_mode == 2) ? 1'($urandom_range(0, 1)) : (rv_mode == 1);
    if (m_q.size() > 0)
      rdata = (corrupt && m_recv == 0) ? 10'h010 : 10'(m_q[0]);
    else
      rdata = 10'($urandom_range(0, 1023));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      step();
    end
    chk("done_within_budget", done, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({wdata, wvalid, rready, busy, done, pass, timeout}), 0);
    chk({name, "_cnt"}, int'({sent_count, recv_count, err_count}), 0);
  endtask

  initial begin : main
    int e1;
    #3;
    chk_all_zero("reset_outputs");
    #19;
    reset = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_wvalid", wvalid, 0);
      chk("idle_rready", rready, 0);
    end

    // Run 1: first command held under wready stall, then golden run.
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_wvalid", wvalid, 1);
      chk("hold_wdata", wdata, 10'h0E1);
      chk("hold_sent", sent_count, 0);
    end
    wr_mode = 1;
    step();
    wr_mode = 0;
    step();
    chk("after_1st_sent", sent_count, 1);
    chk("second_wdata", wdata, 10'h270);
    rv_mode = 1;
    step();
    chk("first_resp", rdata, 10'h00F);
    step();
    chk("first_recv", recv_count, 1);
    chk("first_err", err_count, 0);
    wr_mode = 1;
    wait_done(2000);
    chk("run1_pass", pass, 1);
    chk("run1_sent", sent_count, NUM);
    chk("run1_recv", recv_count, NUM);
    chk("run1_err", err_count, 0);
    log1 = log_cur;

    // Run 2: no results ever returned.
    wr_mode = 1;
    rv_mode = 0;
    pulse_start();
    e1 = -1;
    for (int i = 0; i < 50 && e1 < 0; i++) begin
      if (sent_count == 8'd1) e1 = cyc;
      else step();
    end
    chk("to_first_accept_seen", int'(e1 >= 0), 1);
    wait_done(TMO + 50);
    chk("to_latency", cyc - e1, TMO);
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_sent", sent_count, MAXO);
    chk("to_recv", recv_count, 0);

    // Run 3: first result corrupted.
    corrupt = 1'b1;
    rv_mode = 1;
    pulse_start();
    wait_done(2000);
    chk("err_err", err_count, 1);
    chk("err_recv", recv_count, NUM);
    chk("err_pass", pass, 0);
    chk("err_timeout", timeout, 0);
    corrupt = 1'b0;

    // Run 4: fill queue, pop while full, then random stalls.
    rv_mode = 0;
    pulse_start();
    for (int i = 0; i < 14; i++) step();
    chk("full_wvalid", wvalid, 0);
    chk("full_sent", sent_count, MAXO);
    rv_mode = 1;
    for (int i = 0; i < 6; i++) step();
    wr_mode = 2;
    rv_mode = 2;
    wait_done(4000);
    chk("st_pass", pass, 1);
    chk("st_sent", sent_count, NUM);
    chk("st_recv", recv_count, NUM);
    chk("st_err", err_count, 0);
    chk("st_log_len", log_cur.size(), log1.size());
    for (int i = 0; i < NUM && i < log_cur.size() && i < log1.size(); i++)
      chk($sformatf("repeat_cmd[%0d]", i), log_cur[i], log1[i]);

    // Run 5: reset mid-run.
    wr_mode = 1;
    rv_mode = 1;
    pulse_start();
    for (int i = 0; i < 20; i++) step();
    reset = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_wvalid", wvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: run did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
